// File: rtl/camera_pkg.sv
// Shared definitions for the camera capture path: FSM encoding and default frame geometry.
package camera_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_WRITE      = 2'd2,
    ST_COMMIT     = 2'd3
  } state_t;

  localparam int DEF_FRAME_W = 640;
  localparam int DEF_FRAME_H = 480;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a single-bit level, one cycle of history.
module edge_detect (
  input  logic p_clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge p_clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/camera_frame_writer.sv
// Writes camera pixels into one of NUM_BUF BRAM frame buffers and commits only complete frames.
module camera_frame_writer
  import camera_pkg::*;
#(
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int FRAME_H = DEF_FRAME_H,
  parameter int NUM_BUF = 2,
  parameter int ADDR_W  = 20
) (
  input  logic              p_clk,
  input  logic              rst,
  input  logic              cmos_frame_done,
  input  logic              pixel_valid,
  input  logic              capture_en,
  output logic              bram_write_enable,
  output logic [ADDR_W-1:0] bram_address,
  output logic              wr_buf,
  output logic              rd_buf,
  output logic              frame_ready,
  output logic              frame_error,
  output logic [15:0]       frame_count
);

  localparam int NPIX  = FRAME_W * FRAME_H;
  localparam int IDX_W = $clog2(NPIX + 1);
  localparam logic [IDX_W-1:0]  IDX_FULL = IDX_W'(NPIX);
  localparam logic [ADDR_W-1:0] BUF_SIZE = ADDR_W'(NPIX);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] index;
  logic             overflow;
  logic             done_rise;
  logic             idx_full;
  logic             frame_good;
  logic             pix_accept;
  logic             pix_drop;

  edge_detect u_done_edge (
    .p_clk (p_clk),
    .rst   (rst),
    .d     (cmos_frame_done),
    .rise  (done_rise)
  );

  assign idx_full   = (index == IDX_FULL);
  assign frame_good = idx_full & ~overflow;
  // A pixel arriving together with the frame-end edge belongs to no frame and is dropped.
  assign pix_accept = (state == ST_WRITE) & pixel_valid & ~done_rise & ~idx_full;
  assign pix_drop   = (state == ST_WRITE) & pixel_valid & ~done_rise &  idx_full;

  always_ff @(posedge p_clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       if (cmos_frame_done && capture_en) state_nxt = ST_WAIT_START;
      ST_WAIT_START: if (!cmos_frame_done)              state_nxt = ST_WRITE;
      ST_WRITE:      if (done_rise)                     state_nxt = ST_COMMIT;
      ST_COMMIT:     state_nxt = capture_en ? ST_WAIT_START : ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_ready = 1'b0;
    frame_error = 1'b0;
    if (state == ST_COMMIT) begin
      frame_ready =  frame_good;
      frame_error = ~frame_good;
    end
  end

  always_ff @(posedge p_clk or posedge rst) begin
    if (rst) begin
      index             <= '0;
      overflow          <= 1'b0;
      bram_write_enable <= 1'b0;
      bram_address      <= '0;
      wr_buf            <= 1'b0;
      rd_buf            <= 1'b0;
      frame_count       <= 16'd0;
    end else begin
      bram_write_enable <= pix_accept;
      if (state == ST_WAIT_START && !cmos_frame_done) begin
        index    <= '0;
        overflow <= 1'b0;
      end
      if (pix_accept) begin
        bram_address <= (wr_buf ? BUF_SIZE : '0) + ADDR_W'(index);
        index        <= index + 1'b1;
      end
      if (pix_drop) overflow <= 1'b1;
      // Single-buffer builds keep both buffer selects pinned at 0.
      if (frame_ready) begin
        rd_buf      <= wr_buf;
        wr_buf      <= (NUM_BUF == 2) ? ~wr_buf : 1'b0;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_camera_frame_writer.sv
// Directed table-driven bench for camera_frame_writer with a 4x2 frame and two buffers.
module tb_camera_frame_writer;

  logic        p_clk = 1'b0;
  logic        rst;
  logic        cmos_frame_done;
  logic        pixel_valid;
  logic        capture_en;
  logic        bram_write_enable;
  logic [3:0]  bram_address;
  logic        wr_buf;
  logic        rd_buf;
  logic        frame_ready;
  logic        frame_error;
  logic [15:0] frame_count;

  camera_frame_writer #(
    .FRAME_W (4),
    .FRAME_H (2),
    .NUM_BUF (2),
    .ADDR_W  (4)
  ) dut (
    .p_clk             (p_clk),
    .rst               (rst),
    .cmos_frame_done   (cmos_frame_done),
    .pixel_valid       (pixel_valid),
    .capture_en        (capture_en),
    .bram_write_enable (bram_write_enable),
    .bram_address      (bram_address),
    .wr_buf            (wr_buf),
    .rd_buf            (rd_buf),
    .frame_ready       (frame_ready),
    .frame_error       (frame_error),
    .frame_count       (frame_count)
  );

  always #5 p_clk = ~p_clk;

  typedef struct {
    logic        done;
    logic        pv;
    logic        cap;
    logic        we;
    logic [3:0]  addr;
    logic        wr;
    logic        rd;
    logic        rdy;
    logic        err;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic d, input logic p, input logic c, input logic we,
                     input int addr, input logic wr, input logic rd, input logic rdy,
                     input logic err, input int cnt);
    vec_t v;
    v.done = d;  v.pv = p;   v.cap = c;   v.we = we;  v.addr = addr[3:0];
    v.wr   = wr; v.rd = rd;  v.rdy = rdy; v.err = err; v.cnt = cnt[15:0];
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic we, input logic [3:0] addr,
                         input logic wr, input logic rd, input logic rdy, input logic err,
                         input logic [15:0] cnt);
    chk({tag, ".we"},    idx, 16'(bram_write_enable), 16'(we));
    chk({tag, ".addr"},  idx, 16'(bram_address),      16'(addr));
    chk({tag, ".wr"},    idx, 16'(wr_buf),            16'(wr));
    chk({tag, ".rd"},    idx, 16'(rd_buf),            16'(rd));
    chk({tag, ".ready"}, idx, 16'(frame_ready),       16'(rdy));
    chk({tag, ".error"}, idx, 16'(frame_error),       16'(err));
    chk({tag, ".count"}, idx, frame_count,            cnt);
  endtask

  task automatic step(input logic d, input logic p, input logic c);
    @(negedge p_clk);
    cmos_frame_done = d;
    pixel_valid     = p;
    capture_en      = c;
    @(posedge p_clk);
    #1;
  endtask

  initial begin
    // frame 1: good, buffer 0; the pixel coinciding with the end edge must not count
    add(1,0,1, 0,0, 0,0,0,0,0);
    add(0,0,1, 0,0, 0,0,0,0,0);
    for (int i = 0; i < 8; i++) add(0,1,1, 1,i, 0,0,0,0,0);
    add(1,1,1, 0,7, 0,0,1,0,0);
    add(1,0,1, 0,7, 1,0,0,0,1);
    // frame 2: good, buffer 1
    add(0,0,1, 0,7, 1,0,0,0,1);
    for (int i = 0; i < 8; i++) add(0,1,1, 1,8+i, 1,0,0,0,1);
    add(1,0,1, 0,15, 1,0,1,0,1);
    add(1,0,1, 0,15, 0,1,0,0,2);
    // frame 3: short (6 pixels), end-edge pixel dropped
    add(0,0,1, 0,15, 0,1,0,0,2);
    for (int i = 0; i < 6; i++) add(0,1,1, 1,i, 0,1,0,0,2);
    add(1,1,1, 0,5, 0,1,0,1,2);
    add(1,0,1, 0,5, 0,1,0,0,2);
    // frame 4: long (10 pixels), only 8 written
    add(0,0,1, 0,5, 0,1,0,0,2);
    for (int i = 0; i < 8; i++) add(0,1,1, 1,i, 0,1,0,0,2);
    add(0,1,1, 0,7, 0,1,0,0,2);
    add(0,1,1, 0,7, 0,1,0,0,2);
    add(1,0,1, 0,7, 0,1,0,1,2);
    add(1,0,1, 0,7, 0,1,0,0,2);
    // frame 5: capture_en drops mid-frame, frame still commits, then rests in IDLE
    add(0,0,1, 0,7, 0,1,0,0,2);
    add(0,1,1, 1,0, 0,1,0,0,2);
    for (int i = 1; i < 8; i++) add(0,1,0, 1,i, 0,1,0,0,2);
    add(1,0,0, 0,7, 0,1,1,0,2);
    add(1,0,0, 0,7, 1,0,0,0,3);
    add(0,0,0, 0,7, 1,0,0,0,3);
    add(0,1,0, 0,7, 1,0,0,0,3);
    add(1,1,0, 0,7, 1,0,0,0,3);
    add(0,1,0, 0,7, 1,0,0,0,3);

    rst = 1'b1;
    cmos_frame_done = 1'b1;
    pixel_valid     = 1'b0;
    capture_en      = 1'b1;
    repeat (2) @(posedge p_clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge p_clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].done, vecs[i].pv, vecs[i].cap);
      chk_all("table", i, vecs[i].we, vecs[i].addr, vecs[i].wr, vecs[i].rd,
              vecs[i].rdy, vecs[i].err, vecs[i].cnt);
    end

    // reset in the middle of a frame written to buffer 1
    step(1, 0, 1);
    step(0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1);
      chk_all("prerst", i, 1, 4'(8 + i), 1, 0, 0, 0, 3);
    end
    #2 rst = 1'b1;
    #1;
    chk_all("asyncrst", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge p_clk);
    rst = 1'b0;
    // pixels without a fresh frame start must not be written
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 1);
      chk_all("postrst", i, 0, 0, 0, 0, 0, 0, 0);
    end
    step(1, 0, 1);
    step(0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 1);
      chk_all("refill", i, 1, 4'(i), 0, 0, 0, 0, 0);
    end
    step(1, 0, 1);
    chk_all("refill_commit", 0, 0, 7, 0, 0, 1, 0, 0);
    step(1, 0, 1);
    chk_all("refill_after", 0, 0, 7, 1, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
